ifetch: RTL

Instruction fetch stage of the MIPS pipeline. Owns the program counter, drives the address of the combinational instruction memory (`imem`), and captures the returned word. Presents instruction plus PC+4 to decode through a valid/ready handshake, with a two-entry skid buffer so decode back-pressure never drops a fetched word. Accepts single-cycle redirects (branch/jump) from later stages.

---
 rtl/mips_pkg.sv | 6 +
 rtl/fetch_skid.sv | 55 +++++
 rtl/ifetch.sv | 43 ++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the fetch stage
package mips_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} fetch_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: two-entry output/skid buffer feeding decode
module fetch_skid
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] push_data,
  output logic        valid,
  output logic        full,
  output logic [63:0] out_data
);
  fetch_state_t state, state_n;
  logic [63:0] out_q, out_n, sk_q, sk_n;
  assign valid = state != EMPTY;
  assign full = state == TWO;
  assign out_data = out_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= EMPTY;
      out_q <= '0;
      sk_q <= '0;
    end else begin
      state <= state_n;
      out_q <= out_n;
      sk_q <= sk_n;
    end
  // flush overrides the state only; stale data in invalid entries is harmless
  always_comb begin
    state_n = state;
    out_n = out_q;
    sk_n = sk_q;
    case (state)
      EMPTY: if (push) begin
        out_n = push_data;
        state_n = ONE;
      end
      ONE: if (pop) begin
        out_n = push ? push_data : out_q;
        state_n = push ? ONE : EMPTY;
      end else if (push) begin
        sk_n = push_data;
        state_n = TWO;
      end
      TWO: if (pop) begin
        out_n = sk_q;
        state_n = ONE;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: program counter, redirect handling and imem capture for decode
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        misalign_err
);
  logic [31:0] pc, pc4;
  logic full, fetch;
  assign pc4 = pc + PC_STEP;
  assign imem_addr = pc;
  assign fetch = !redirect_valid && !full;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch ? pc4 : pc;
      misalign_err <= redirect_valid && redirect_pc[1:0] != 2'b00;
    end
  fetch_skid u_skid (
    .clk(clk),
    .reset(reset),
    .push(fetch),
    .pop(id_valid && id_ready),
    .flush(redirect_valid),
    .push_data({imem_rdata, pc4}),
    .valid(id_valid),
    .full(full),
    .out_data({id_instr, id_pc4})
  );
endmodule
